// File: rtl/load_store_unit.sv
// Requester-side load/store unit for the byte-granular data cache port: one request in, one response out.
// Optional build macro MISALIGN_TRAP_EN turns misaligned halfword/word accesses into immediate errors.
module load_store_unit #(
    parameter logic [31:0] CACHE_SIZE   = 32'd1024,
    parameter logic [31:0] CACHE_OFFSET = 32'h0000_1000,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [31:0] cache_addr,
    output logic [31:0] cache_wdata,
    output logic        cache_op,
    input  logic [31:0] cache_rdata
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_ISSUE = 3'd1;
    localparam logic [2:0] S_RD_WAIT  = 3'd2;
    localparam logic [2:0] S_WR_BYTE  = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam logic [7:0]  LAT_LAST   = 8'(READ_LATENCY - 1);
    localparam logic [32:0] WINDOW_END = {1'b0, CACHE_OFFSET} + {1'b0, CACHE_SIZE};

    logic [2:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  wait_q, wait_d;
    logic        reqReady_q, reqReady_d;
    logic        rspValid_q, rspValid_d;
    logic [31:0] rspData_q, rspData_d;
    logic        rspErr_q, rspErr_d;
    logic [31:0] cacheAddr_q, cacheAddr_d;
    logic [31:0] cacheWdata_q, cacheWdata_d;
    logic        cacheOp_q, cacheOp_d;

    logic [2:0]  reqBytes;
    logic [32:0] reqEnd;
    logic        reqF3Ok, reqInRange, reqMisalign, reqErr;
    logic [1:0]  lastByte;
    logic [7:0]  wrByte;
    logic [31:0] loadExt;

    // Request legality is decided up front so a bad request never touches the cache.
    always_comb begin
        case (req_funct3[1:0])
            2'd0:    reqBytes = 3'd1;
            2'd1:    reqBytes = 3'd2;
            default: reqBytes = 3'd4;
        endcase
        if (req_store) reqF3Ok = req_funct3 inside {3'd0, 3'd1, 3'd2};
        else           reqF3Ok = req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        // The 33-bit end address makes a wrap past 0xFFFFFFFF fall outside the window.
        reqEnd     = {1'b0, req_addr} + {30'b0, reqBytes};
        reqInRange = (req_addr >= CACHE_OFFSET) && (reqEnd <= WINDOW_END);
`ifdef MISALIGN_TRAP_EN
        reqMisalign = ((reqBytes == 3'd2) && req_addr[0]) ||
                      ((reqBytes == 3'd4) && (req_addr[1:0] != 2'b00));
`else
        reqMisalign = 1'b0;
`endif
        reqErr = !reqF3Ok || !reqInRange || reqMisalign;
    end

    always_comb begin
        case (funct3_q[1:0])
            2'd0:    lastByte = 2'd0;
            2'd1:    lastByte = 2'd1;
            default: lastByte = 2'd3;
        endcase
        case (cnt_q)
            2'd0:    wrByte = wdata_q[7:0];
            2'd1:    wrByte = wdata_q[15:8];
            2'd2:    wrByte = wdata_q[23:16];
            default: wrByte = wdata_q[31:24];
        endcase
        case (funct3_q)
            3'd0:    loadExt = {{24{cache_rdata[7]}}, cache_rdata[7:0]};
            3'd1:    loadExt = {{16{cache_rdata[15]}}, cache_rdata[15:0]};
            3'd4:    loadExt = {24'b0, cache_rdata[7:0]};
            3'd5:    loadExt = {16'b0, cache_rdata[15:0]};
            default: loadExt = cache_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        funct3_d     = funct3_q;
        cnt_d        = cnt_q;
        wait_d       = wait_q;
        reqReady_d   = reqReady_q;
        rspValid_d   = rspValid_q;
        rspData_d    = rspData_q;
        rspErr_d     = rspErr_q;
        cacheAddr_d  = cacheAddr_q;
        cacheWdata_d = cacheWdata_q;
        cacheOp_d    = cacheOp_q;
        case (state_q)
            S_IDLE: begin
                reqReady_d = 1'b1;
                if (req_valid && reqReady_q) begin
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    funct3_d   = req_funct3;
                    reqReady_d = 1'b0;
                    if (reqErr) begin
                        state_d    = S_DONE;
                        rspValid_d = 1'b1;
                        rspErr_d   = 1'b1;
                        rspData_d  = '0;
                    end else if (req_store) begin
                        state_d = S_WR_BYTE;
                        cnt_d   = 2'd0;
                    end else begin
                        state_d = S_RD_ISSUE;
                    end
                end
            end
            S_RD_ISSUE: begin
                cacheAddr_d = addr_q;
                cacheOp_d   = 1'b0;
                wait_d      = 8'd0;
                state_d     = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (wait_q == LAT_LAST) begin
                    rspData_d  = loadExt;
                    rspErr_d   = 1'b0;
                    rspValid_d = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WR_BYTE: begin
                cacheAddr_d  = addr_q + {30'b0, cnt_q};
                cacheWdata_d = {24'b0, wrByte};
                cacheOp_d    = 1'b1;
                cnt_d        = cnt_q + 2'd1;
                if (cnt_q == lastByte) begin
                    rspData_d  = '0;
                    rspErr_d   = 1'b0;
                    rspValid_d = 1'b1;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                cacheOp_d = 1'b0;
                if (rspReady_accept(rspValid_q, rsp_ready)) begin
                    rspValid_d = 1'b0;
                    reqReady_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    function automatic logic rspReady_accept(input logic v, input logic r);
        return v && r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            funct3_q     <= '0;
            cnt_q        <= '0;
            wait_q       <= '0;
            reqReady_q   <= 1'b0;
            rspValid_q   <= 1'b0;
            rspData_q    <= '0;
            rspErr_q     <= 1'b0;
            cacheAddr_q  <= '0;
            cacheWdata_q <= '0;
            cacheOp_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            funct3_q     <= funct3_d;
            cnt_q        <= cnt_d;
            wait_q       <= wait_d;
            reqReady_q   <= reqReady_d;
            rspValid_q   <= rspValid_d;
            rspData_q    <= rspData_d;
            rspErr_q     <= rspErr_d;
            cacheAddr_q  <= cacheAddr_d;
            cacheWdata_q <= cacheWdata_d;
            cacheOp_q    <= cacheOp_d;
        end
    end

    assign req_ready   = reqReady_q;
    assign rsp_valid   = rspValid_q;
    assign rsp_data    = rspData_q;
    assign rsp_err     = rspErr_q;
    assign cache_addr  = cacheAddr_q;
    assign cache_wdata = cacheWdata_q;
    assign cache_op    = cacheOp_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit against a byte-wide asynchronous-read cache model.
// Honours MISALIGN_TRAP_EN the same way the design does when computing expected responses.
module tb_load_store_unit;

    localparam logic [31:0] OFF  = 32'h0000_1000;
    localparam logic [31:0] SIZE = 32'd1024;
    localparam int          LAT  = 1;

    logic        clk, rst;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;
    logic [31:0] cache_addr, cache_wdata, cache_rdata;
    logic        cache_op;

    load_store_unit #(.CACHE_SIZE(SIZE), .CACHE_OFFSET(OFF), .READ_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_op(cache_op),
        .cache_rdata(cache_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cache model: combinational read, byte write on posedge, with a write log for ordering checks.
    logic [7:0]  cacheMem [0:1023];
    logic [31:0] wrAddrLog [0:255];
    int          wrCount = 0;
    logic        memClear;

    always_comb begin
        cache_rdata = '0;
        for (int i = 0; i < 4; i++)
            if ((cache_addr + 32'(i)) - OFF < SIZE)
                cache_rdata[8*i +: 8] = cacheMem[10'((cache_addr + 32'(i)) - OFF)];
    end

    always @(posedge clk) begin
        if (memClear) begin
            for (int i = 0; i < 1024; i++) cacheMem[i] <= 8'h00;
        end else if (cache_op) begin
            if (cache_addr - OFF < SIZE) cacheMem[10'(cache_addr - OFF)] <= cache_wdata[7:0];
            if (wrCount < 256) wrAddrLog[wrCount] <= cache_addr;
            wrCount <= wrCount + 1;
        end
    end

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          nb;
    } expect_t;

    expect_t     sbQ [$];
    logic [7:0]  refMem [0:1023];
    int          passCount = 0;
    int          checkCount = 0;
    string       curTest = "init";

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp)
            $display("[TB] FAIL %s/%s: got 0x%08h, expected 0x%08h", curTest, tag, obs, exp);
        else
            passCount++;
    endtask

    function automatic int modelBytes(input logic [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic modelErr(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int  nb;
        logic legal, mis;
        nb    = modelBytes(f3);
        legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        mis   = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis = (nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00);
`endif
        return !legal || mis || (a < OFF) || (({1'b0, a} + 33'(nb)) > ({1'b0, OFF} + {1'b0, SIZE}));
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] a);
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) begin
            if ((a + 32'(i)) - OFF < SIZE) b[i] = refMem[10'((a + 32'(i)) - OFF)];
            else                           b[i] = 8'h00;
        end
        case (f3)
            3'd0:    return {{24{b[0][7]}}, b[0]};
            3'd1:    return {{16{b[1][7]}}, b[1], b[0]};
            3'd4:    return {24'h0, b[0]};
            3'd5:    return {16'h0, b[1], b[0]};
            default: return {b[3], b[2], b[1], b[0]};
        endcase
    endfunction

    // Pushes the model's expectation, runs one request/response and compares against the popped entry.
    task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input int hold);
        expect_t e, got;
        int      startWr, n, k;
        logic [31:0] heldData;
        e.err  = modelErr(st, f3, a);
        e.data = (e.err || st) ? 32'h0 : modelLoad(f3, a);
        e.nb   = (e.err || !st) ? 0 : modelBytes(f3);
        e.lat  = e.err ? 1 : (st ? 1 + modelBytes(f3) : 2 + LAT);
        sbQ.push_back(e);
        if (!e.err && st)
            for (int i = 0; i < modelBytes(f3); i++) refMem[10'(a - OFF + 32'(i))] = wd[8*i +: 8];
        startWr = wrCount;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) checkOutput("ready_timeout", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 1;
        while (!rsp_valid && k < 40) begin @(negedge clk); k++; end
        got = sbQ.pop_front();
        checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("latency", 32'(k), 32'(got.lat));
        checkOutput("rsp_err", 32'(rsp_err), 32'(got.err));
        checkOutput("rsp_data", rsp_data, got.data);
        heldData = rsp_data;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
            checkOutput("hold_data", rsp_data, heldData);
            checkOutput("hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("rsp_cleared", 32'(rsp_valid), 32'd0);
        checkOutput("ready_again", 32'(req_ready), 32'd1);
        checkOutput("write_count", 32'(wrCount - startWr), 32'(got.nb));
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int base, n;
        for (int i = 0; i < 1024; i++) refMem[i] = 8'h00;
        rst = 1'b1; memClear = 1'b1;
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd2;
        req_addr = OFF; req_wdata = 32'h0; rsp_ready = 1'b0;

        // Reset with a request pending: nothing is accepted and every output is zero.
        curTest = "reset";
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("req_ready", 32'(req_ready), 32'd0);
        checkOutput("rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rsp_data", rsp_data, 32'd0);
        checkOutput("rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("cache_addr", cache_addr, 32'd0);
        checkOutput("cache_wdata", cache_wdata, 32'd0);
        checkOutput("cache_op", 32'(cache_op), 32'd0);
        rst = 1'b0; memClear = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_rst", 32'(req_ready), 32'd1);
        checkOutput("no_accept", 32'(rsp_valid), 32'd0);

        curTest = "ext";
        applyStimulus(1'b1, 3'd0, OFF + 4, 32'h0000_0080, 0);
        applyStimulus(1'b1, 3'd0, OFF + 5, 32'h0000_0012, 0);
        applyStimulus(1'b0, 3'd0, OFF + 4, 32'h0, 0);
        applyStimulus(1'b0, 3'd5, OFF + 4, 32'h0, 0);
        applyStimulus(1'b0, 3'd1, OFF + 4, 32'h0, 0);
        applyStimulus(1'b0, 3'd4, OFF + 4, 32'h0, 0);

        curTest = "sw";
        base = wrCount;
        applyStimulus(1'b1, 3'd2, OFF + 8, 32'hDEAD_BEEF, 0);
        for (int i = 0; i < 4; i++) checkOutput("wr_order", wrAddrLog[base + i], OFF + 8 + 32'(i));
        checkOutput("mem_b0", 32'(cacheMem[8]), 32'h0000_00EF);
        checkOutput("mem_b3", 32'(cacheMem[11]), 32'h0000_00DE);
        applyStimulus(1'b0, 3'd2, OFF + 8, 32'h0, 0);
        applyStimulus(1'b1, 3'd1, OFF + 12, 32'h0000_8001, 0);
        applyStimulus(1'b0, 3'd1, OFF + 12, 32'h0, 0);

        curTest = "hold";
        applyStimulus(1'b0, 3'd2, OFF + 8, 32'h0, 3);

        curTest = "errors";
        applyStimulus(1'b1, 3'd2, OFF + SIZE - 2, 32'h1234_5678, 0);
        applyStimulus(1'b0, 3'd3, OFF + 8, 32'h0, 0);
        applyStimulus(1'b1, 3'd4, OFF + 8, 32'h0, 0);
        applyStimulus(1'b0, 3'd2, 32'hFFFF_FFFE, 32'h0, 0);
        applyStimulus(1'b0, 3'd0, OFF - 1, 32'h0, 0);
        applyStimulus(1'b1, 3'd2, OFF + SIZE - 4, 32'h1122_3344, 0);
        applyStimulus(1'b0, 3'd2, OFF + SIZE - 4, 32'h0, 1);

        curTest = "misalign";
        applyStimulus(1'b0, 3'd2, OFF + 1, 32'h0, 0);
        applyStimulus(1'b1, 3'd1, OFF + 21, 32'h0000_A55A, 0);
        applyStimulus(1'b0, 3'd5, OFF + 21, 32'h0, 0);

        // Reset in the middle of a word store: the response is dropped and the last byte is never written.
        curTest = "abort";
        base = wrCount;
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd2;
        req_addr = OFF + 32; req_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while ((wrCount - base) < 2 && n < 20) begin @(negedge clk); n++; end
        checkOutput("two_bytes", 32'(wrCount - base), 32'd2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_op", 32'(cache_op), 32'd0);
        checkOutput("rst_valid", 32'(rsp_valid), 32'd0);
        repeat (4) @(negedge clk);
        checkOutput("no_rsp", 32'(rsp_valid), 32'd0);
        checkOutput("idle_ready", 32'(req_ready), 32'd1);
        checkOutput("b3_untouched", 32'(cacheMem[35]), 32'(refMem[35]));
        applyStimulus(1'b0, 3'd0, OFF + 4, 32'h0, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
